// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-serial load/store unit: funct3 codes,
// FSM state encoding and the access-size decode.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    // Number of bytes moved for funct3[1:0]; 0 marks the unsupported size.
    function automatic logic [2:0] size_of(input logic [1:0] sz);
        case (sz)
            2'b00:   size_of = 3'd1;
            2'b01:   size_of = 3'd2;
            2'b10:   size_of = 3'd4;
            default: size_of = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_master_load_extend.sv
// Combinational sign/zero extension of the assembled load buffer.
module load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        ext = '0;
        case (funct3)
            F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
            F3_BU:   ext = {24'h0, raw[7:0]};
            F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
            F3_HU:   ext = {16'h0, raw[15:0]};
            F3_W:    ext = raw;
            default: ext = '0;
        endcase
    end

endmodule

// File: rtl/lsu_byte_master.sv
// MEM-stage load/store initiator: splits one RV32I access into little-endian
// byte handshakes on an 8-bit memory port and returns extended load data.
module lsu_byte_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    lsu_state_e        state_q, state_d;
    logic              write_q, write_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        k_q, k_d;
    logic [31:0]       buf_q, buf_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0] ext_data;
    logic [2:0]  last_idx;
    logic        is_last;
    logic        req_illegal;

    assign last_idx = size_of(funct3_q[1:0]) - 3'd1;
    assign is_last  = ({1'b0, k_q} == last_idx);

    assign req_illegal = (req_funct3[1:0] == 2'b11)
                      || (req_write && req_funct3[2])
                      || ((req_funct3[1:0] == 2'b01) && req_addr[0])
                      || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    // Kept apart from the FSM block so the extender sees the buffer including
    // the byte arriving this cycle without forming a combinational loop.
    always_comb begin
        buf_d = buf_q;
        if (state_q == IDLE && req_valid) begin
            buf_d = '0;
        end else if (state_q == XFER && mem_ready && !write_q) begin
            buf_d[8*k_q +: 8] = mem_rdata;
        end
    end

    load_extend u_load_extend (
        .funct3 (funct3_q),
        .raw    (buf_d),
        .ext    (ext_data)
    );

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        k_d       = k_q;
        wdog_d    = wdog_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        mem_addr  = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        busy      = (state_q != IDLE);
        done      = (state_q == RESP);
        err       = (state_q == RESP) && err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    k_d      = '0;
                    wdog_d   = '0;
                    if (req_illegal) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = XFER;
                    end
                end
            end
            XFER: begin
                mem_addr  = addr_q + ADDR_W'(k_q);
                mem_re    = !write_q;
                mem_we    = write_q;
                mem_wdata = wdata_q[8*k_q +: 8];
                if (mem_ready) begin
                    wdog_d = '0;
                    k_d    = k_q + 2'd1;
                    if (is_last) begin
                        rdata_d = write_q ? 32'h0 : ext_data;
                        state_d = RESP;
                    end
                end else begin
                    wdog_d = wdog_q + 1'b1;
                    // Partial load data is dropped when the responder stalls out.
                    if (wdog_d == WD_W'(TIMEOUT_CYC)) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            k_q      <= '0;
            buf_q    <= '0;
            wdog_q   <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            k_q      <= k_d;
            buf_q    <= buf_d;
            wdog_q   <= wdog_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_lsu_byte_master.sv
// Self-checking bench for lsu_byte_master: a byte-addressed responder memory
// plus a transaction-level golden memory and load-result model.
module tb_lsu_byte_master;

    localparam int ADDR_W = 32;
    localparam int TO     = 16;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ready;

    int errors = 0;
    int checks = 0;

    logic [7:0] resp_mem [256];
    logic [7:0] gold_mem [256];

    lsu_byte_master #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) resp_mem[i] = 8'((i * 37 + 11) % 256);
    end

    assign mem_rdata = mem_re ? resp_mem[mem_addr[7:0]] : 8'h00;

    always @(posedge clk) begin
        if (mem_we && mem_ready) resp_mem[mem_addr[7:0]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_bytes(input logic [2:0] f3);
        int sz;
        case (f3[1:0])
            2'b00:   sz = 1;
            2'b01:   sz = 2;
            2'b10:   sz = 4;
            default: sz = 0;
        endcase
        return sz;
    endfunction

    function automatic bit is_legal(input bit wr, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = size_bytes(f3);
        if (sz == 0) return 1'b0;
        if (wr && f3[2]) return 1'b0;
        return (a % sz) == 0;
    endfunction

    // Little-endian value read from the golden memory, extended numerically.
    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
        int     sz;
        longint v;
        logic [7:0] gi;
        sz = size_bytes(f3);
        v  = 0;
        for (int i = 0; i < sz; i++) begin
            gi = 8'(a + 32'(i));
            v  = v + longint'(gold_mem[gi]) * (longint'(1) << (8 * i));
        end
        if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return 32'(v);
    endfunction

    task automatic applyStimulus(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input int stall_k, input int stall_n,
                                 input bit noisy, output logic [31:0] rd_out);
        int          sz, exp_done, mk, stalled, cyc, eff_stall;
        bit          legal, tmo, got;
        logic [31:0] exp_rd, sh, ea;
        logic [7:0]  gi;

        sz        = size_bytes(f3);
        legal     = is_legal(wr, f3, a);
        eff_stall = (legal && stall_k < sz) ? stall_n : 0;
        tmo       = legal && (eff_stall >= TO);
        if (!legal)   exp_done = 1;
        else if (tmo) exp_done = stall_k + TO + 1;
        else          exp_done = sz + eff_stall + 1;
        exp_rd = (!legal || wr || tmo) ? 32'h0 : exp_load(f3, a);
        rd_out = 'x;

        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        mem_ready  = 1'b1;
        @(posedge clk);

        mk = 0; stalled = 0; cyc = 0; got = 1'b0;
        while (cyc < 200 && !got) begin
            @(negedge clk);
            cyc++;
            if (noisy) begin
                req_valid  = 1'b1;
                req_write  = 1'($urandom_range(0, 1));
                req_funct3 = 3'($urandom_range(0, 7));
                req_addr   = $urandom;
                req_wdata  = $urandom;
            end else begin
                req_valid  = 1'b0;
            end
            if (done) begin
                got = 1'b1;
                rd_out = rdata;
                chk("done_cycle", 32'(cyc), 32'(exp_done));
                chk("err", 32'(err), 32'(!legal || tmo));
                chk("rdata", rdata, exp_rd);
                chk("resp_no_access", {30'h0, mem_re, mem_we}, 32'h0);
                req_valid = 1'b0;
            end else begin
                chk("busy", 32'(busy), 32'h1);
                if (legal && mk < sz) begin
                    ea = a + 32'(mk);
                    chk("mem_addr", mem_addr, ea);
                    chk("re_we", {30'h0, mem_re, mem_we}, {30'h0, !wr, wr});
                    sh = wd >> (8 * mk);
                    if (wr) chk("mem_wdata", 32'(mem_wdata), {24'h0, sh[7:0]});
                    if (mk == stall_k && stalled < stall_n) begin
                        mem_ready = 1'b0;
                        stalled++;
                    end else begin
                        mem_ready = 1'b1;
                        if (wr) begin
                            gi = ea[7:0];
                            gold_mem[gi] = sh[7:0];
                        end
                        mk++;
                    end
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));
                end
            end
        end
        chk("done_seen", 32'(got), 32'h1);
        @(negedge clk);
        chk("idle_after", {30'h0, busy, done}, 32'h0);
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_re_we"}, {30'h0, mem_re, mem_we}, 32'h0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
    endtask

    initial begin
        logic [31:0] rd, wd, a;
        logic [2:0]  f3s [6];
        logic [2:0]  f3;
        logic [7:0]  gi;
        bit          wr;

        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
        for (int i = 0; i < 256; i++) gold_mem[i] = 8'((i * 37 + 11) % 256);

        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset");
        reset = 1'b1;

        applyStimulus(1'b1, 3'b010, 32'h4, 32'hDEADBEEF, 9, 0, 1'b0, rd);
        applyStimulus(1'b0, 3'b010, 32'h4, 32'h0, 9, 0, 1'b0, rd);
        chk("sw_lw_back", rd, 32'hDEADBEEF);

        applyStimulus(1'b1, 3'b000, 32'h10, 32'h80, 9, 0, 1'b0, rd);
        applyStimulus(1'b0, 3'b000, 32'h10, 32'h0, 9, 0, 1'b0, rd);
        chk("lb_const", rd, 32'hFFFFFF80);
        applyStimulus(1'b0, 3'b100, 32'h10, 32'h0, 9, 0, 1'b0, rd);
        chk("lbu_const", rd, 32'h00000080);
        applyStimulus(1'b1, 3'b001, 32'h20, 32'h9234, 9, 0, 1'b0, rd);
        applyStimulus(1'b0, 3'b001, 32'h20, 32'h0, 9, 0, 1'b0, rd);
        chk("lh_const", rd, 32'hFFFF9234);
        applyStimulus(1'b0, 3'b101, 32'h20, 32'h0, 9, 0, 1'b0, rd);
        chk("lhu_const", rd, 32'h00009234);

        applyStimulus(1'b0, 3'b010, 32'h2, 32'h0, 9, 0, 1'b0, rd);
        applyStimulus(1'b0, 3'b011, 32'h0, 32'h0, 9, 0, 1'b0, rd);
        applyStimulus(1'b1, 3'b100, 32'h0, 32'h55, 9, 0, 1'b0, rd);
        applyStimulus(1'b0, 3'b001, 32'h21, 32'h0, 9, 0, 1'b0, rd);

        applyStimulus(1'b0, 3'b010, 32'h4, 32'h0, 1, 3, 1'b0, rd);
        chk("lw_stall_data", rd, 32'hDEADBEEF);

        applyStimulus(1'b0, 3'b010, 32'h8, 32'h0, 0, TO, 1'b0, rd);
        applyStimulus(1'b0, 3'b010, 32'h8, 32'h0, 2, 100, 1'b0, rd);
        applyStimulus(1'b1, 3'b010, 32'h30, 32'hA1B2C3D4, 2, TO, 1'b0, rd);
        applyStimulus(1'b0, 3'b010, 32'h30, 32'h0, 3, TO - 1, 1'b0, rd);
        applyStimulus(1'b0, 3'b000, 32'hFFFFFFFF, 32'h0, 9, 0, 1'b0, rd);

        applyStimulus(1'b0, 3'b001, 32'h4, 32'h0, 0, 2, 1'b1, rd);

        for (int t = 0; t < 40; t++) begin
            wr = 1'($urandom_range(0, 1));
            f3 = wr ? f3s[$urandom_range(0, 2)] : f3s[$urandom_range(0, 5)];
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
            wd = $urandom;
            applyStimulus(wr, f3, a, wd, $urandom_range(0, 4),
                          ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 3),
                          1'($urandom_range(0, 1)), rd);
        end

        wd = $urandom;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h40; req_wdata = wd; mem_ready = 1'b1;
        @(posedge clk);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            req_valid = 1'b0;
            mem_ready = 1'b1;
            gi = 8'(32'h40 + 32'(b));
            gold_mem[gi] = 8'(wd >> (8 * b));
        end
        @(negedge clk);
        mem_ready = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort");
        reset = 1'b1;
        applyStimulus(1'b0, 3'b010, 32'h40, 32'h0, 9, 0, 1'b0, rd);
        chk("abort_low_half", {16'h0, rd[15:0]}, {16'h0, wd[15:0]});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
